// File: rtl/calc_pkg.sv
// Shared encodings for the calculator entry/execution controller.
// States, operator codes and the default operand width.
package calc_pkg;

  localparam int CALC_W = 8;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_CALC = 3'd3,
    S_SHOW = 3'd4
  } state_e;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

endpackage

// File: rtl/seq_divider.sv
// W-cycle restoring divider, one quotient bit per cycle, MSB first.
// quotient/remainder present the value after the current step, so they are final while done is high.
module seq_divider
  import calc_pkg::*;
#(
  parameter int W = CALC_W
) (
  input  logic         clck,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  r_rem;
  logic [W-1:0]  r_quot;
  logic [W-1:0]  r_dvs;
  logic [CW-1:0] r_cnt;
  logic          r_active;

  logic [W:0]    w_trial;
  logic          w_fits;
  logic [W-1:0]  w_sub;
  logic [W-1:0]  w_rem_nxt;
  logic [W-1:0]  w_quot_nxt;

  // Partial remainder stays below the divisor, so the trial difference always fits in W bits.
  assign w_trial    = {r_rem, r_quot[W-1]};
  assign w_fits     = (w_trial >= {1'b0, r_dvs});
  assign w_sub      = w_trial[W-1:0] - r_dvs;
  assign w_rem_nxt  = w_fits ? w_sub : w_trial[W-1:0];
  assign w_quot_nxt = {r_quot[W-2:0], w_fits};

  assign done      = r_active && (r_cnt == CW'(1));
  assign quotient  = w_quot_nxt;
  assign remainder = w_rem_nxt;

  always_ff @(posedge clck or negedge rst_n) begin
    if (!rst_n) begin
      r_rem    <= '0;
      r_quot   <= '0;
      r_dvs    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (abort) begin
      r_rem    <= '0;
      r_quot   <= '0;
      r_dvs    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (start) begin
      r_rem    <= '0;
      r_quot   <= dividend;
      r_dvs    <= divisor;
      r_cnt    <= CW'(W);
      r_active <= 1'b1;
    end else if (r_active) begin
      r_rem  <= w_rem_nxt;
      r_quot <= w_quot_nxt;
      r_cnt  <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) begin
        r_active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/calc_entry_fsm.sv
// Operand/operator entry and execution controller for the calculator.
// state | meaning: S_A capture A, S_B capture B, S_OP capture operator, S_CALC execute, S_SHOW hold result.
module calc_entry_fsm
  import calc_pkg::*;
#(
  parameter int W = CALC_W
) (
  input  logic           clck,
  input  logic           rst_n,
  input  logic [W-1:0]   sw_val,
  input  logic [1:0]     op_sel,
  input  logic           enter_pe,
  input  logic           clear_pe,
  output logic [2*W-1:0] result,
  output logic           result_valid,
  output logic           busy,
  output logic           err_div0,
  output logic [2:0]     state_dbg
);

  state_e         r_state;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [1:0]     r_op;
  logic [2*W-1:0] r_result;
  logic           r_result_valid;
  logic           r_busy;
  logic           r_err_div0;

  logic           w_div_start;
  logic           w_div_done;
  logic [W-1:0]   w_quot;
  logic [W-1:0]   w_rem;
  logic [2*W-1:0] w_a_ext;
  logic [2*W-1:0] w_b_ext;

  assign w_a_ext = {{W{1'b0}}, r_a};
  assign w_b_ext = {{W{1'b0}}, r_b};

  // Divider is loaded on the same edge that enters S_CALC, so it finishes on the W-th S_CALC edge.
  assign w_div_start = (r_state == S_OP) && enter_pe && !clear_pe &&
                       (op_sel == OP_DIV) && (r_b != '0);

  seq_divider #(.W(W)) u_div (
    .clck      (clck),
    .rst_n     (rst_n),
    .start     (w_div_start),
    .abort     (clear_pe),
    .dividend  (r_a),
    .divisor   (r_b),
    .done      (w_div_done),
    .quotient  (w_quot),
    .remainder (w_rem)
  );

  always_ff @(posedge clck or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_A;
      r_a            <= '0;
      r_b            <= '0;
      r_op           <= OP_ADD;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_err_div0     <= 1'b0;
    end else if (clear_pe) begin
      r_state        <= S_A;
      r_a            <= '0;
      r_b            <= '0;
      r_op           <= OP_ADD;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_err_div0     <= 1'b0;
    end else begin
      case (r_state)
        S_A: begin
          if (enter_pe) begin
            r_a     <= sw_val;
            r_state <= S_B;
          end
        end
        S_B: begin
          if (enter_pe) begin
            r_b     <= sw_val;
            r_state <= S_OP;
          end
        end
        S_OP: begin
          if (enter_pe) begin
            r_op    <= op_sel;
            r_state <= S_CALC;
            r_busy  <= 1'b1;
          end
        end
        S_CALC: begin
          case (r_op)
            OP_ADD: begin
              r_result       <= w_a_ext + w_b_ext;
              r_state        <= S_SHOW;
              r_busy         <= 1'b0;
              r_result_valid <= 1'b1;
            end
            OP_SUB: begin
              r_result       <= w_a_ext - w_b_ext;
              r_state        <= S_SHOW;
              r_busy         <= 1'b0;
              r_result_valid <= 1'b1;
            end
            OP_MUL: begin
              r_result       <= w_a_ext * w_b_ext;
              r_state        <= S_SHOW;
              r_busy         <= 1'b0;
              r_result_valid <= 1'b1;
            end
            default: begin
              if (r_b == '0) begin
                r_result       <= '1;
                r_err_div0     <= 1'b1;
                r_state        <= S_SHOW;
                r_busy         <= 1'b0;
                r_result_valid <= 1'b1;
              end else if (w_div_done) begin
                r_result       <= {w_rem, w_quot};
                r_state        <= S_SHOW;
                r_busy         <= 1'b0;
                r_result_valid <= 1'b1;
              end
            end
          endcase
        end
        S_SHOW: begin
          if (enter_pe) begin
            r_state        <= S_A;
            r_result_valid <= 1'b0;
            r_err_div0     <= 1'b0;
          end
        end
        default: begin
          r_state        <= S_A;
          r_busy         <= 1'b0;
          r_result_valid <= 1'b0;
        end
      endcase
    end
  end

  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign busy         = r_busy;
  assign err_div0     = r_err_div0;
  assign state_dbg    = r_state;

endmodule

// File: tb/tb_calc_entry_fsm.sv
// Directed testbench for calc_entry_fsm (W=8) with hand-computed expectations.
module tb_calc_entry_fsm;

  logic        clck = 1'b0;
  logic        rst_n;
  logic [7:0]  sw_val;
  logic [1:0]  op_sel;
  logic        enter_pe;
  logic        clear_pe;
  logic [15:0] result;
  logic        result_valid;
  logic        busy;
  logic        err_div0;
  logic [2:0]  state_dbg;

  int n_chk = 0;
  int n_err = 0;
  int cyc;

  always #5 clck = ~clck;

  calc_entry_fsm #(.W(8)) dut (
    .clck         (clck),
    .rst_n        (rst_n),
    .sw_val       (sw_val),
    .op_sel       (op_sel),
    .enter_pe     (enter_pe),
    .clear_pe     (clear_pe),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .err_div0     (err_div0),
    .state_dbg    (state_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic press();
    @(negedge clck);
    enter_pe = 1'b1;
    @(negedge clck);
    enter_pe = 1'b0;
  endtask

  task automatic enter_operands(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    sw_val = a;
    press();
    sw_val = b;
    press();
    op_sel = op;
    press();
  endtask

  // Counts sampled cycles with busy high; optionally pokes enter while busy.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                        input bit inject, output int n_busy);
    enter_operands(a, b, op);
    n_busy = 0;
    while (busy === 1'b1 && n_busy < 50) begin
      n_busy++;
      enter_pe = inject && (n_busy == 2 || n_busy == 5);
      @(negedge clck);
    end
    enter_pe = 1'b0;
  endtask

  task automatic check_show(input string tag, input logic [15:0] exp_res, input logic exp_err);
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_valid"}, result_valid, 1'b1);
    chk({tag, "_state"}, state_dbg, 3'd4);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_err"}, err_div0, exp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    sw_val   = '0;
    op_sel   = '0;
    enter_pe = 1'b0;
    clear_pe = 1'b0;
    #12;
    chk("rst_state", state_dbg, 3'd0);
    chk("rst_result", result, 16'h0000);
    chk("rst_valid", result_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err_div0, 1'b0);
    @(negedge clck);
    rst_n = 1'b1;

    run_op(8'd25, 8'd17, 2'd0, 1'b0, cyc);
    chk("add_cycles", cyc, 1);
    check_show("add", 16'h002A, 1'b0);
    press();
    chk("add_ret_state", state_dbg, 3'd0);
    chk("add_ret_valid", result_valid, 1'b0);
    chk("add_ret_hold", result, 16'h002A);

    run_op(8'd5, 8'd9, 2'd1, 1'b0, cyc);
    chk("sub_cycles", cyc, 1);
    check_show("sub", 16'hFFFC, 1'b0);
    press();

    run_op(8'd255, 8'd255, 2'd2, 1'b0, cyc);
    chk("mul_cycles", cyc, 1);
    check_show("mul", 16'hFE01, 1'b0);
    press();

    run_op(8'd200, 8'd7, 2'd3, 1'b1, cyc);
    chk("div_cycles", cyc, 8);
    check_show("div", 16'h041C, 1'b0);
    press();
    chk("div_ret_state", state_dbg, 3'd0);

    run_op(8'd9, 8'd0, 2'd3, 1'b0, cyc);
    chk("div0_cycles", cyc, 1);
    check_show("div0", 16'hFFFF, 1'b1);
    press();
    chk("div0_ret_state", state_dbg, 3'd0);
    chk("div0_ret_err", err_div0, 1'b0);
    chk("div0_ret_valid", result_valid, 1'b0);
    chk("div0_ret_hold", result, 16'hFFFF);

    // Clear together with enter in the middle of a division.
    enter_operands(8'd200, 8'd7, 2'd3);
    chk("clr_pre_busy", busy, 1'b1);
    repeat (3) @(negedge clck);
    clear_pe = 1'b1;
    enter_pe = 1'b1;
    @(negedge clck);
    clear_pe = 1'b0;
    enter_pe = 1'b0;
    chk("clr_state", state_dbg, 3'd0);
    chk("clr_busy", busy, 1'b0);
    chk("clr_result", result, 16'h0000);
    chk("clr_valid", result_valid, 1'b0);
    chk("clr_err", err_div0, 1'b0);
    repeat (12) @(negedge clck);
    chk("clr_late_valid", result_valid, 1'b0);
    chk("clr_late_state", state_dbg, 3'd0);
    chk("clr_late_result", result, 16'h0000);

    // Clear beats enter while showing a result.
    run_op(8'd3, 8'd4, 2'd0, 1'b0, cyc);
    check_show("add2", 16'h0007, 1'b0);
    @(negedge clck);
    clear_pe = 1'b1;
    enter_pe = 1'b1;
    @(negedge clck);
    clear_pe = 1'b0;
    enter_pe = 1'b0;
    chk("clrshow_state", state_dbg, 3'd0);
    chk("clrshow_result", result, 16'h0000);

    // Asynchronous reset in the middle of a division, away from any clock edge.
    enter_operands(8'd200, 8'd7, 2'd3);
    repeat (3) @(negedge clck);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_state", state_dbg, 3'd0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_result", result, 16'h0000);
    chk("arst_valid", result_valid, 1'b0);
    chk("arst_err", err_div0, 1'b0);
    @(negedge clck);
    rst_n = 1'b1;
    repeat (10) @(negedge clck);
    chk("arst_late_valid", result_valid, 1'b0);

    run_op(8'd255, 8'd16, 2'd3, 1'b0, cyc);
    chk("div2_cycles", cyc, 8);
    check_show("div2", 16'h0F0F, 1'b0);
    press();

    run_op(8'd100, 8'd200, 2'd0, 1'b0, cyc);
    check_show("add3", 16'h012C, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/calc_entry_fsm.md
Name: calc_entry_fsm

Overview:
- Operand/operator entry and execution controller for the calculator, directly downstream of the positive-edge detector.
- Consumes single-cycle button pulses (enter, clear) plus switch values to capture operand A, operand B and the operator.
- Executes the operation (add, sub, mul, sequential divide) and holds the result for the display stage.

Parameters:
- W, 8, operand width in bits; result width is 2*W.

Ports:
- clck  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- sw_val  input  W  operand switches, sampled on enter.
- op_sel  input  2  operator switches: 0 add, 1 sub, 2 mul, 3 div.
- enter_pe  input  1  one-cycle pulse from the edge detector on the enter button.
- clear_pe  input  1  one-cycle pulse from the edge detector on the clear button.
- result  output  2W  registered result.
- result_valid  output  1  high while in S_SHOW.
- busy  output  1  high while in S_CALC.
- err_div0  output  1  sticky divide-by-zero flag, cleared on leaving S_SHOW.
- state_dbg  output  3  current state encoding.

Behaviour:
- Reset (async, rst_n=0): state=S_A; the A, B, op registers, result, result_valid, busy, err_div0 and divider regs are all 0.
- State encoding: S_A=0, S_B=1, S_OP=2, S_CALC=3, S_SHOW=4. Other codes go to S_A.
- S_A: enter_pe latches a=sw_val, then S_B.
- S_B: enter_pe latches b=sw_val, then S_OP.
- S_OP: enter_pe latches op=op_sel, then S_CALC.
- S_CALC, add/sub/mul: exactly 1 cycle. The result is registered on the edge that moves to S_SHOW.
- S_CALC, div with b!=0: exactly W cycles of restoring division, one quotient bit per cycle, MSB first. Result={remainder[W-1:0], quotient[W-1:0]} is registered on the W-th edge, then S_SHOW.
- S_CALC, div with b==0: 1 cycle. result=all ones, err_div0=1, then S_SHOW.
- S_SHOW: result_valid=1 and result is held. enter_pe returns to S_A, drops result_valid and err_div0, and keeps the result value until the next calculation.
- Arithmetic:
  - add: zero-extended to 2W, carry kept.
  - sub: 2W-bit two's complement of a-b, zero-extended operands.
  - mul: unsigned full 2W product.
- enter_pe during S_CALC is ignored; it is not queued.
- clear_pe in any state: on the next edge go to S_A and zero a, b, op, result, result_valid, err_div0 and the divider. clear_pe has priority over a simultaneous enter_pe. Clear mid-division aborts with no result update.
- enter_pe high for N consecutive cycles counts as N events; the upstream edge detector guarantees single-cycle pulses.
- Async reset mid-division behaves identically to the reset state; no partial result survives.
- busy = (state==S_CALC), registered alongside state.

Decomposition:
- Package calc_pkg holds the state encodings (S_A..S_SHOW), op codes (OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3) and the default W.
- Sub-module seq_divider:
  - Inputs: clck, rst_n, start, abort, dividend, divisor.
  - Outputs: done, quotient, remainder.
  - W-cycle restoring divider.
  - The FSM pulses start on entry to S_CALC with op=div and b!=0, and pulses abort on clear_pe.

Test Plan (W=8):
- Assert rst_n=0 mid-run -> state_dbg=0, result=0, result_valid=0, busy=0, err_div0=0 immediately (async).
- a=25, b=17, op=add, enter pulses -> busy for 1 cycle, then result=16'h002A, result_valid=1.
- a=5, b=9, op=sub -> result=16'hFFFC.
- a=255, b=255, op=mul -> result=16'hFE01.
- a=200, b=7, op=div -> busy exactly 8 cycles, result=16'h041C (rem 4, quot 28). Extra enter pulses during busy are ignored.
- a=9, b=0, op=div -> 1 cycle, result=16'hFFFF, err_div0=1. Then enter -> S_A with err_div0=0.
- Mid-division clear_pe together with enter_pe -> S_A, all registers 0, result_valid stays 0.
